// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared button indices, FSM encoding and grant priority
package parking_pkg;

  localparam int NUM_BTN  = 6;

  localparam int IDX_ADD1 = 0;
  localparam int IDX_ADD2 = 1;
  localparam int IDX_ADD3 = 2;
  localparam int IDX_ADD4 = 3;
  localparam int IDX_RST1 = 4;
  localparam int IDX_RST2 = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Highest priority first: presets beat adds, larger adds beat smaller ones.
  localparam logic [2:0] PRIO_ORDER [NUM_BTN] = '{
    3'(IDX_RST2), 3'(IDX_RST1), 3'(IDX_ADD4),
    3'(IDX_ADD3), 3'(IDX_ADD2), 3'(IDX_ADD1)
  };

  // Walk from lowest to highest priority so the last hit is the winner.
  function automatic logic [2:0] pick_winner(input logic [NUM_BTN-1:0] req);
    logic [2:0] idx;
    idx = PRIO_ORDER[NUM_BTN-1];
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) idx = PRIO_ORDER[i];
    end
    return idx;
  endfunction

endpackage

// File: rtl/parking_cmd_scheduler_if.sv
// rtl/parking_cmd_scheduler_if.sv - button inputs and timer command outputs of the scheduler
interface parking_cmd_scheduler_if #(
  parameter int CNT_W = 8
);

  logic [5:0]       btn_raw;
  logic             add1_p;
  logic             add2_p;
  logic             add3_p;
  logic             add4_p;
  logic             rst1_p;
  logic             rst2_p;
  logic [5:0]       pending;
  logic             busy;
  logic [CNT_W-1:0] issued_cnt;

  modport master (
    output btn_raw,
    input  add1_p, add2_p, add3_p, add4_p, rst1_p, rst2_p,
    input  pending, busy, issued_cnt
  );

  modport slave (
    input  btn_raw,
    output add1_p, add2_p, add3_p, add4_p, rst1_p, rst2_p,
    output pending, busy, issued_cnt
  );

endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-FF sync, debounce and rising-edge pulse for one button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then flip the level only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_async;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_cmd_scheduler.sv
// rtl/parking_cmd_scheduler.sv - latches conditioned presses and issues them as spaced single-cycle pulses
module parking_cmd_scheduler
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_W           = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  parking_cmd_scheduler_if.slave  bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pend_clr;
  logic [NUM_BTN-1:0] pulse;
  logic [2:0]         winner;
  logic [GW-1:0]      gap_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  state_t             state;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_cond
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_async(bus.btn_raw[g]),
      .rise     (rise[g])
    );
  end

  // Pick the grant and the pending bits it retires; a preset also drops queued adds.
  always_comb begin
    winner   = pick_winner(pending);
    pend_clr = '0;
    if (state == S_IDLE && pending != '0) begin
      pend_clr[winner] = 1'b1;
      if (winner == 3'(IDX_RST1) || winner == 3'(IDX_RST2)) begin
        pend_clr[IDX_ADD4:IDX_ADD1] = '1;
      end
    end
  end

  // Grant FSM with registered pulse/busy/count; new rising edges always win over clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= '0;
      pulse   <= '0;
      gap_cnt <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= (pending & ~pend_clr) | rise;
      case (state)
        S_IDLE: begin
          if (pending != '0) begin
            pulse <= NUM_BTN'(1) << winner;
            cnt   <= cnt + 1'b1;
            busy  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          pulse <= '0;
          if (GAP_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= GW'(GAP_CYCLES);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          pulse <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.add1_p     = pulse[IDX_ADD1];
  assign bus.add2_p     = pulse[IDX_ADD2];
  assign bus.add3_p     = pulse[IDX_ADD3];
  assign bus.add4_p     = pulse[IDX_ADD4];
  assign bus.rst1_p     = pulse[IDX_RST1];
  assign bus.rst2_p     = pulse[IDX_RST2];
  assign bus.pending    = pending;
  assign bus.busy       = busy;
  assign bus.issued_cnt = cnt;

endmodule

// File: doc/parking_cmd_scheduler.md
Name: parking_cmd_scheduler

Overview:
- Sits between the raw push-buttons and the parking meter countdown timer.
- Conditions six asynchronous buttons (add1..add4, rst1, rst2) by synchronising, debouncing and edge-detecting each one.
- Latches presses as pending requests and grants them one at a time in fixed priority.
- Each grant is a single-cycle command pulse, so the timer never sees two commands in one cycle or a held button.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive identical samples required before a conditioned level changes (clk is 100 Hz, so 30 ms).
- GAP_CYCLES, 2: idle cycles forced after every issued pulse before the next grant.
- CNT_W, 8: width of the issued-command counter.

Ports:
- clk  in  1  system clock, 100 Hz.
- rst_n  in  1  synchronous active-low reset.
- btn_raw  in  6  raw asynchronous buttons, active-high; bit 0 add1, 1 add2, 2 add3, 3 add4, 4 rst1, 5 rst2.
- add1_p, add2_p, add3_p, add4_p  out  1 each  single-cycle command pulses to the timer.
- rst1_p, rst2_p  out  1 each  single-cycle preset pulses to the timer.
- pending  out  6  currently latched, not-yet-issued requests, same bit order as btn_raw.
- busy  out  1  high in ISSUE or GAP.
- issued_cnt  out  CNT_W  total pulses issued since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset: applied at any clk edge with rst_n=0, including mid-ISSUE or mid-GAP. Clears all synchronisers, debounce counters, conditioned levels, pending, the FSM (to IDLE), the gap counter and issued_cnt. All outputs read 0 the cycle after.
- Conditioning, per bit:
  - 2-FF synchroniser feeds the debouncer.
  - The debounce counter counts while the synchronised sample differs from the conditioned level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a differing sample, the conditioned level flips.
  - A rising edge of the conditioned level sets pending[i].
  - Holding a button yields exactly one request; a falling edge does nothing.
- Latency: a raw press held from cycle 0 sets pending at cycle 2+DEBOUNCE_CYCLES+1. This is 6 cycles with the defaults and is the exact value checked.
- Pending set/clear in the same cycle: set wins, so a new press is never lost.
- Priority, highest first: rst2, rst1, add4, add3, add2, add1.
- FSM states:
  - IDLE: if pending != 0, latch the highest-priority index and go to ISSUE. Otherwise stay.
  - ISSUE, exactly 1 cycle:
    - Assert the corresponding *_p output for this cycle only.
    - Clear that pending bit.
    - Increment issued_cnt.
    - If the index is rst1 or rst2, also clear pending[3:0], because a preset supersedes queued adds.
    - Load the gap counter with GAP_CYCLES and go to GAP, or go to IDLE if GAP_CYCLES=0.
  - GAP: decrement the gap counter each cycle. Go to IDLE when it reaches 1. New presses keep latching during GAP.
- Pulse outputs are registered and at most one is high in any cycle (one-hot or zero).
- Minimum spacing between consecutive pulses is GAP_CYCLES+2 cycles (ISSUE, GAP_CYCLES, IDLE). Arbitration is registered in IDLE.
- Buttons pressed in the same cycle are all latched and issued in priority order, unless flushed by a preset.
- A re-press of a button whose pending bit is already set is absorbed: there is no queue depth beyond 1 per button.
- issued_cnt wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package parking_pkg:
  - Button index constants: IDX_ADD1=0 .. IDX_RST2=5.
  - NUM_BTN=6.
  - FSM state encoding: S_IDLE, S_ISSUE, S_GAP.
  - Priority order as a constant list.
- Sub-module button_conditioner, instantiated 6 times: 2-FF sync, debounce counter, conditioned level, rising-edge pulse.
- The scheduler holds the pending register, arbiter, FSM and counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with btn_raw=6'h3F, then release with btn_raw=0 → all outputs 0, pending=0, issued_cnt=0; no pulse for 20 cycles.
- Single press with bounce: add1 toggles 1,0,1,0 on consecutive cycles, then holds 1 for 50 cycles → exactly one add1_p pulse, issued_cnt=1; pending[0] rises 6 cycles after the stable-1 start.
- Simultaneous adds: add1, add3 and add4 pressed in the same cycle and held → pulses in order add4_p, add3_p, add1_p, each one cycle wide, separated by exactly 4 cycles; issued_cnt=3.
- Preset flush: add2 and add1 pending, then rst2 pressed before they issue, with the FSM still in GAP from a prior pulse → next pulse is rst2_p, pending[3:0] cleared, no add pulses follow.
- Mid-operation reset: rst_n driven low on the ISSUE cycle → that cycle's pulse is still the registered output; the next cycle shows all pulses 0, pending=0, busy=0.
- Counter wrap: CNT_W=2, issue 5 separate add1 presses → issued_cnt sequence 1,2,3,0,1.
